mem_data: RTL and testbench



---
 rtl/mem_data_pkg.sv | 41 ++++
 rtl/mem_data_lane.sv | 48 ++++
 rtl/mem_data.sv | 159 +++++++++++++++
 tb/tb_mem_data.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_data_pkg.sv
// Shared definitions for the data-memory responder: load/store size codes,
// FSM state encoding, wait-state counter width and the alignment/size check.
package mem_data_pkg;

    // RV32I funct3 load/store size encodings
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // Wait-state counter holds 0..15
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size/alignment fault, independent of the array depth:
    // reserved sizes, unsigned stores, odd halfwords, unaligned words.
    function automatic logic access_fault(
        input logic       is_store,
        input logic [2:0] size,
        input logic [1:0] addr_lo
    );
        logic fault;
        fault = 1'b0;
        case (size)
            LDST_B:  fault = 1'b0;
            LDST_H:  fault = addr_lo[0];
            LDST_W:  fault = (addr_lo != 2'b00);
            LDST_BU: fault = is_store;
            LDST_HU: fault = is_store | addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_data_lane.sv
// Byte-lane steering: store byte enables and data replication, plus load
// lane selection with sign/zero extension. Purely combinational.
module mem_data_lane
    import mem_data_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Per-lane enable and store data: bytes replicate wdata[7:0] to every
    // lane, halves replicate wdata[15:0] to both halves, words pass through.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_en[gi] =
                (size[1:0] == 2'd0) ? (addr_lo == 2'(gi)) :
                (size[1:0] == 2'd1) ? (addr_lo[1] == 1'(gi / 2)) :
                (size[1:0] == 2'd2);
            assign wdata_rep[8*gi +: 8] =
                (size[1:0] == 2'd0) ? wdata[7:0] :
                (size[1:0] == 2'd1) ? wdata[8*(gi % 2) +: 8] :
                                      wdata[8*gi +: 8];
        end
    endgenerate

    // Load lane select and extension according to funct3
    always_comb begin
        sel_byte = rword[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (size)
            LDST_B:  ldata = {{24{sel_byte[7]}}, sel_byte};
            LDST_BU: ldata = {24'b0, sel_byte};
            LDST_H:  ldata = {{16{sel_half[15]}}, sel_half};
            LDST_HU: ldata = {16'b0, sel_half};
            LDST_W:  ldata = rword;
            default: ldata = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_data.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_STATES wait cycles while stalling the core, then strobes a single
// response cycle carrying extended load data or an error flag.
module mem_data
    import mem_data_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;

    logic        we_reg;
    logic [2:0]  size_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        valid_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem_array [DEPTH_WORDS];

    logic        accept;
    logic        resp_enter;
    logic        cur_we;
    logic [2:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic        cur_range_err;
    logic        cur_err;
    logic [31:0] cur_word;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] ldata;

    assign accept = (state_reg == ST_IDLE) && req_i;

    // With zero wait states the access completes on the accept edge, before
    // the latched copies exist, so the live inputs are used while in IDLE.
    always_comb begin
        cur_we    = (state_reg == ST_IDLE) ? we_i    : we_reg;
        cur_size  = (state_reg == ST_IDLE) ? size_i  : size_reg;
        cur_addr  = (state_reg == ST_IDLE) ? addr_i  : addr_reg;
        cur_wdata = (state_reg == ST_IDLE) ? wdata_i : wdata_reg;
    end

    assign cur_range_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_err       = access_fault(cur_we, cur_size, cur_addr[1:0]) | cur_range_err;
    assign cur_idx       = cur_addr[2 +: IDX_W];
    assign cur_word      = mem_array[cur_idx];

    mem_data_lane u_lane (
        .size      (cur_size),
        .addr_lo   (cur_addr[1:0]),
        .wdata     (cur_wdata),
        .rword     (cur_word),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .ldata     (ldata)
    );

    // State and wait counter registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and counter: IDLE -> WAIT/RESP on request, WAIT counts down
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_i) begin
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Stall while a request is being accepted or waiting; released in RESP
    always_comb begin
        stall_o = accept || (state_reg == ST_WAIT);
    end

    assign resp_enter = (state_next == ST_RESP);

    // Request latches and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            size_reg  <= 3'b0;
            addr_reg  <= 32'b0;
            wdata_reg <= 32'b0;
            valid_reg <= 1'b0;
            rdata_reg <= 32'b0;
            err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                we_reg    <= we_i;
                size_reg  <= size_i;
                addr_reg  <= addr_i;
                wdata_reg <= wdata_i;
            end
            valid_reg <= resp_enter;
            err_reg   <= resp_enter && cur_err;
            rdata_reg <= (resp_enter && !cur_we && !cur_err) ? ldata : 32'b0;
        end
    end

    // Byte-masked array write on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && resp_enter && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_array[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign valid_o = valid_reg;
    assign rdata_o = rdata_reg;
    assign err_o   = err_reg;

endmodule

// File: tb/tb_mem_data.sv
// Bench for mem_data: three instances (1, 0 and 3 wait states) checked every
// cycle against a byte-array / cycle-count model, plus literal expectations.
module tb_mem_data;
    import mem_data_pkg::*;

    localparam int NI    = 3;
    localparam int DEPTH = 256;
    localparam int WS [NI] = '{1, 0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NI];
    logic        req   [NI];
    logic        we    [NI];
    logic [2:0]  size  [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic        stall [NI];
    logic        valid [NI];
    logic [31:0] rdata [NI];
    logic        err   [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            mem_data #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS[gi])) u_dut (
                .clk     (clk),
                .rst     (rst[gi]),
                .req_i   (req[gi]),
                .we_i    (we[gi]),
                .size_i  (size[gi]),
                .addr_i  (addr[gi]),
                .wdata_i (wdata[gi]),
                .stall_o (stall[gi]),
                .valid_o (valid[gi]),
                .rdata_o (rdata[gi]),
                .err_o   (err[gi])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [7:0]  mm [NI][4*DEPTH];
    bit          m_live  [NI];
    bit          m_busy  [NI];
    int          m_acc   [NI];
    bit          m_we    [NI];
    logic [2:0]  m_size  [NI];
    logic [31:0] m_addr  [NI];
    logic [31:0] m_wdata [NI];
    logic [31:0] m_rdata [NI];
    bit          m_err   [NI];
    int          cyc = 0;

    int          resp_cnt   [NI];
    logic [31:0] last_rdata [NI];
    logic        last_err   [NI];

    task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h cycle=%0d", nm, k, act, exp, cyc);
        end
    endtask

    function automatic bit model_err(input bit w, input logic [2:0] s, input logic [31:0] a);
        if (s == 3'd3 || s == 3'd6 || s == 3'd7) return 1'b1;
        if (w && s >= 3'd4) return 1'b1;
        if ((s == 3'd1 || s == 3'd5) && a[0]) return 1'b1;
        if (s == 3'd2 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        if (s[1:0] == 2'd0) return 1;
        if (s[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Compare-then-advance model process, one pass per cycle at the falling edge
    initial begin
        bit es, ev;
        int n, base;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (m_live[k]) begin
                    es = m_busy[k] ? (cyc <= m_acc[k] + WS[k]) : req[k];
                    ev = m_busy[k] && (cyc == m_acc[k] + 1 + WS[k]);
                    chk32("stall", k, {31'b0, stall[k]}, {31'b0, es});
                    chk32("valid", k, {31'b0, valid[k]}, {31'b0, ev});
                    if (ev && valid[k]) begin
                        chk32("rdata", k, rdata[k], m_rdata[k]);
                        chk32("err", k, {31'b0, err[k]}, {31'b0, m_err[k]});
                        resp_cnt[k]++;
                        last_rdata[k] = rdata[k];
                        last_err[k]   = err[k];
                    end
                end
                if (rst[k]) begin
                    m_live[k] = 1'b1;
                    m_busy[k] = 1'b0;
                end else if (m_live[k]) begin
                    if (m_busy[k] && cyc == m_acc[k] + 1 + WS[k]) begin
                        m_busy[k] = 1'b0;
                    end else if (!m_busy[k] && req[k]) begin
                        m_busy[k]  = 1'b1;
                        m_acc[k]   = cyc;
                        m_we[k]    = we[k];
                        m_size[k]  = size[k];
                        m_addr[k]  = addr[k];
                        m_wdata[k] = wdata[k];
                        m_err[k]   = model_err(we[k], size[k], addr[k]);
                    end
                    if (m_busy[k] && cyc == m_acc[k] + WS[k]) begin
                        n = nbytes(m_size[k]);
                        m_rdata[k] = 32'b0;
                        if (!m_err[k]) begin
                            base = int'(m_addr[k]);
                            if (m_we[k]) begin
                                for (int i = 0; i < n; i++)
                                    mm[k][base + i] = m_wdata[k][8*i +: 8];
                            end else begin
                                v = 32'b0;
                                for (int i = 0; i < n; i++)
                                    v = v | (32'(mm[k][base + i]) << (8 * i));
                                if (m_size[k] < 3'd4 && n < 4 && v[8*n-1])
                                    v = v | ~((32'd1 << (8 * n)) - 32'd1);
                                m_rdata[k] = v;
                            end
                        end
                    end
                end
            end
            cyc++;
        end
    end

    // One complete access; optionally pins the response to literal values
    task automatic access(input int k, input bit w, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] d, input bit lit, input logic [31:0] exp_rd, input bit exp_er);
        int start;
        bit got;
        start = resp_cnt[k];
        got = 1'b0;
        @(posedge clk); #1;
        req[k] = 1'b1; we[k] = w; size[k] = s; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        req[k] = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            if (resp_cnt[k] != start) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL timeout inst=%0d addr=%h actual=no_response required=response", k, a);
        end else begin
            $display("txn inst=%0d we=%0d size=%0d addr=%h wdata=%h rdata=%h err=%0d",
                     k, w, s, a, d, last_rdata[k], last_err[k]);
            if (lit) begin
                chk32("lit_rdata", k, last_rdata[k], exp_rd);
                chk32("lit_err", k, {31'b0, last_err[k]}, {31'b0, exp_er});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int start;
        bit got;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; size[k] = 3'b0;
            addr[k] = 32'b0; wdata[k] = 32'b0;
            resp_cnt[k] = 0; last_rdata[k] = 32'b0; last_err[k] = 1'b0;
            m_live[k] = 1'b0; m_busy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk32("reset_valid", k, {31'b0, valid[k]}, 32'd0);
            chk32("reset_err", k, {31'b0, err[k]}, 32'd0);
            chk32("reset_rdata", k, rdata[k], 32'd0);
            chk32("reset_stall", k, {31'b0, stall[k]}, 32'd0);
        end

        // One wait state: word, byte and halfword traffic
        access(0, 1, LDST_W,  32'h10, 32'h12345678, 1, 32'h0,        0);
        access(0, 0, LDST_W,  32'h10, 32'h0,        1, 32'h12345678, 0);
        access(0, 1, LDST_B,  32'h13, 32'h000000AB, 1, 32'h0,        0);
        access(0, 0, LDST_B,  32'h13, 32'h0,        1, 32'hFFFFFFAB, 0);
        access(0, 0, LDST_BU, 32'h13, 32'h0,        1, 32'h000000AB, 0);
        access(0, 0, LDST_W,  32'h10, 32'h0,        1, 32'hAB345678, 0);
        access(0, 1, LDST_H,  32'h12, 32'h00008001, 1, 32'h0,        0);
        access(0, 0, LDST_H,  32'h12, 32'h0,        1, 32'hFFFF8001, 0);
        access(0, 0, LDST_HU, 32'h12, 32'h0,        1, 32'h00008001, 0);
        access(0, 0, LDST_W,  32'h10, 32'h0,        1, 32'h80015678, 0);
        // Rejected accesses leave memory untouched
        access(0, 0, LDST_W,  32'h11,  32'h0,        1, 32'h0, 1);
        access(0, 0, LDST_H,  32'h13,  32'h0,        1, 32'h0, 1);
        access(0, 1, LDST_W,  32'h400, 32'hFFFFFFFF, 1, 32'h0, 1);
        access(0, 0, 3'd3,    32'h10,  32'h0,        1, 32'h0, 1);
        access(0, 1, LDST_BU, 32'h10,  32'h00000055, 1, 32'h0, 1);
        access(0, 0, LDST_W,  32'h10,  32'h0,        1, 32'h80015678, 0);
        // Last addressable word
        access(0, 1, LDST_W,  32'h3FC, 32'hA5A55A5A, 1, 32'h0,        0);
        access(0, 0, LDST_HU, 32'h3FE, 32'h0,        1, 32'h0000A5A5, 0);

        // Zero wait states: request held high across back-to-back SW then LW
        start = resp_cnt[1];
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; size[1] = LDST_W; addr[1] = 32'h40; wdata[1] = 32'hCAFEF00D;
        @(posedge clk); #1;
        we[1] = 1'b0; wdata[1] = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            if (resp_cnt[1] == start + 2) got = 1'b1;
        end
        chk32("b2b_responses", 1, 32'(resp_cnt[1] - start), 32'd2);
        chk32("b2b_rdata", 1, last_rdata[1], 32'hCAFEF00D);
        $display("txn inst=1 b2b sw/lw addr=00000040 rdata=%h err=%0d", last_rdata[1], last_err[1]);
        access(1, 0, LDST_B, 32'h41, 32'h0, 1, 32'hFFFFFFF0, 0);

        // Three wait states: reset in the second WAIT cycle aborts the store
        access(2, 1, LDST_W, 32'h20, 32'h0BADF00D, 1, 32'h0, 0);
        start = resp_cnt[2];
        @(posedge clk); #1;
        req[2] = 1'b1; we[2] = 1'b1; size[2] = LDST_W; addr[2] = 32'h20; wdata[2] = 32'hDEADBEEF;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        chk32("abort_stall", 2, {31'b0, stall[2]}, 32'd0);
        repeat (6) @(posedge clk);
        chk32("abort_no_valid", 2, 32'(resp_cnt[2] - start), 32'd0);
        $display("txn inst=2 aborted sw addr=00000020 wdata=deadbeef responses=%0d", resp_cnt[2] - start);
        access(2, 0, LDST_W, 32'h20, 32'h0, 1, 32'h0BADF00D, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
